// File: rtl/nios_test_board_pio_btn.sv
// Avalon-MM button/switch PIO: each input bit is synchronized, debounced, and
// edge-detected into a sticky capture register that can raise a masked,
// registered level interrupt. Four-word register map with zero-wait reads.
// WIDTH is expected in 1..32, DEBOUNCE in 1..65535, EDGE_TYPE in 0..2.
module nios_test_board_pio_btn #(
    parameter int WIDTH     = 8,
    parameter int DEBOUNCE  = 4,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_RSVD    = 2'd1,
        REG_MASK    = 2'd2,
        REG_CAPTURE = 2'd3
    } reg_sel_e;

    // Counter value at which a persistent difference is accepted.
    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE - 1);

    reg_sel_e          reg_sel;
    logic              wr_en;

    logic [WIDTH-1:0]  sync1_q;
    logic [WIDTH-1:0]  sync2_q;
    logic [WIDTH-1:0]  deb_q, deb_d;
    logic [15:0]       cnt_q [WIDTH];
    logic [15:0]       cnt_d [WIDTH];
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  cap_q, cap_d;
    logic [WIDTH-1:0]  cap_set;
    logic [WIDTH-1:0]  cap_clr;
    logic              irq_q, irq_d;

    assign reg_sel = reg_sel_e'(address);
    assign wr_en   = chipselect && !write_n;

    // Upper write-data bits have no destination when WIDTH < 32.
    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:WIDTH];
    end

    // Two-flop synchronizer: the only logic that touches raw in_port.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values;
        // blocking = here would chain sync1 into sync2 within one edge.
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: count consecutive cycles sync2 disagrees with deb.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a variable unassigned, which would infer a latch.
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Debounced value and its counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q <= '0;
            // NOTE: the counter array is ordinary flops, not a RAM, and must be
            // reset so a debounce interrupted by reset restarts from zero.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Edge selection on the debounced value, evaluated on the updating edge.
    always_comb begin
        unique case (EDGE_TYPE)
            0:       cap_set = deb_d & ~deb_q;
            1:       cap_set = ~deb_d & deb_q;
            default: cap_set = deb_d ^ deb_q;
        endcase
    end

    // Bus writes: mask load and write-1-to-clear of capture (set wins).
    always_comb begin
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr_en && reg_sel == REG_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && reg_sel == REG_CAPTURE) begin
            cap_clr = writedata[WIDTH-1:0];
        end
        cap_d = (cap_q & ~cap_clr) | cap_set;
        irq_d = |(cap_q & mask_q);
    end

    // Mask, capture and interrupt registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            cap_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            cap_q  <= cap_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;

    // Zero-wait read mux, independent of chipselect; unused bits read 0.
    always_comb begin
        readdata = '0;
        unique case (reg_sel)
            REG_DATA:    readdata[WIDTH-1:0] = deb_q;
            REG_MASK:    readdata[WIDTH-1:0] = mask_q;
            REG_CAPTURE: readdata[WIDTH-1:0] = cap_q;
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_test_board_pio_btn.sv
// Scoreboard bench for nios_test_board_pio_btn: three instances share one bus
// and input port, differing only in EDGE_TYPE (0 rising, 1 falling, 2 any).
// Stimulus pushes expected values; a negedge monitor pops and compares.
module tb_nios_test_board_pio_btn;

    localparam int WIDTH = 8;

    typedef struct {
        string       name;
        int          dut;
        bit          is_irq;
        logic [31:0] exp;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      rd_w  [3];
    logic             irq_w [3];

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    nios_test_board_pio_btn #(.WIDTH(WIDTH), .DEBOUNCE(4), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_w[0]), .irq(irq_w[0])
    );
    nios_test_board_pio_btn #(.WIDTH(WIDTH), .DEBOUNCE(4), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_w[1]), .irq(irq_w[1])
    );
    nios_test_board_pio_btn #(.WIDTH(WIDTH), .DEBOUNCE(4), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_w[2]), .irq(irq_w[2])
    );

    // Monitor: outputs are sampled on the falling edge, away from updates.
    always @(negedge clk) begin
        while (sb_q.size() != 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = sb_q.pop_front();
            act = e.is_irq ? {31'd0, irq_w[e.dut]} : rd_w[e.dut];
            n_checks++;
            if (act === e.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s (dut %0d): got 0x%08h, expected 0x%08h",
                         e.name, e.dut, act, e.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input int dut, input logic [1:0] a,
                             input logic [31:0] exp, input string name);
        exp_t e;
        address  = a;
        e.name   = name;
        e.dut    = dut;
        e.is_irq = 1'b0;
        e.exp    = exp;
        sb_q.push_back(e);
    endtask

    task automatic expect_irq(input int dut, input logic exp, input string name);
        exp_t e;
        e.name   = name;
        e.dut    = dut;
        e.is_irq = 1'b1;
        e.exp    = {31'd0, exp};
        sb_q.push_back(e);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        in_port    = '0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #2;
        // Reset state
        expect_rd(0, 2'd0, 32'h0, "reset data");
        expect_irq(0, 1'b0, "reset irq");
        tick(1);
        expect_rd(0, 2'd3, 32'h0, "reset capture");
        tick(1);
        reset_n = 1'b1;
        tick(2);

        // Clean rising step on bit 0: visible at edge k+5
        in_port = 8'h01;
        tick(5);
        expect_rd(0, 2'd0, 32'h0, "data at k+4");
        expect_irq(0, 1'b0, "irq during debounce");
        tick(1);
        expect_rd(0, 2'd0, 32'h1, "data at k+5");
        tick(1);
        for (int d = 0; d < 3; d++) begin
            expect_rd(d, 2'd3, (d == 1) ? 32'h0 : 32'h1, "capture after rise");
        end
        expect_irq(0, 1'b0, "irq masked off");
        tick(2);
        expect_irq(2, 1'b0, "irq masked off any-edge");

        // Falling step on bit 0
        bus_write(2'd3, 32'hFF);
        in_port = 8'h00;
        tick(7);
        for (int d = 0; d < 3; d++) begin
            expect_rd(d, 2'd3, (d == 0) ? 32'h0 : 32'h1, "capture after fall");
        end
        tick(1);
        bus_write(2'd3, 32'hFF);

        // Mask readback (upper bits dropped) and reserved word
        bus_write(2'd2, 32'hABCD_1201);
        expect_rd(0, 2'd2, 32'h01, "mask readback");
        tick(1);
        bus_write(2'd1, 32'hFFFF_FFFF);
        expect_rd(0, 2'd1, 32'h0, "addr1 after write");
        tick(1);

        // Masked rise: capture exactly at k+5, irq one cycle later
        in_port = 8'h01;
        tick(5);
        expect_rd(0, 2'd3, 32'h0, "capture at k+4");
        tick(1);
        expect_rd(0, 2'd3, 32'h1, "capture at k+5");
        expect_irq(0, 1'b0, "irq lags capture");
        tick(1);
        expect_irq(0, 1'b1, "irq after capture");
        expect_irq(2, 1'b1, "irq after capture any-edge");
        expect_irq(1, 1'b0, "irq no fall yet");
        tick(1);
        bus_write(2'd3, 32'h01);
        expect_rd(0, 2'd3, 32'h0, "capture w1c");
        expect_irq(0, 1'b1, "irq held one cycle after clear");
        tick(1);
        expect_irq(0, 1'b0, "irq drops after clear");
        expect_irq(2, 1'b0, "irq drops after clear any-edge");

        // 3-cycle glitch on bit 2 is rejected
        in_port = 8'h05;
        tick(3);
        in_port = 8'h01;
        tick(8);
        expect_rd(0, 2'd0, 32'h01, "glitch data");
        tick(1);
        for (int d = 0; d < 3; d++) begin
            expect_rd(d, 2'd3, 32'h0, "glitch capture");
        end
        expect_irq(0, 1'b0, "glitch irq");

        // 4-cycle pulse on bit 2 is accepted (rise then fall)
        in_port = 8'h05;
        tick(4);
        in_port = 8'h01;
        tick(12);
        for (int d = 0; d < 3; d++) begin
            expect_rd(d, 2'd3, 32'h04, "4-cycle pulse capture");
        end
        expect_irq(0, 1'b0, "unmasked bit no irq");
        tick(1);
        bus_write(2'd3, 32'hFF);

        // Bit 3 rise then fall across edge types
        in_port = 8'h09;
        tick(8);
        for (int d = 0; d < 3; d++) begin
            expect_rd(d, 2'd3, (d == 1) ? 32'h0 : 32'h08, "bit3 rise capture");
        end
        tick(1);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h01;
        tick(8);
        for (int d = 0; d < 3; d++) begin
            expect_rd(d, 2'd3, (d == 0) ? 32'h0 : 32'h08, "bit3 fall capture");
        end
        tick(1);
        bus_write(2'd3, 32'hFF);

        // Clear-write on the same edge bit 0 sets: set wins
        in_port = 8'h00;
        tick(8);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h01;
        tick(5);
        bus_write(2'd3, 32'h01);
        expect_rd(0, 2'd3, 32'h1, "set beats clear");
        expect_rd(2, 2'd3, 32'h1, "set beats clear any-edge");
        expect_rd(1, 2'd3, 32'h0, "no capture on rise falling-type");
        tick(1);
        expect_irq(0, 1'b1, "irq from set-wins capture");

        // Mask clear drops irq one cycle later; re-enable restores it
        tick(1);
        bus_write(2'd2, 32'h0);
        expect_irq(0, 1'b1, "irq before mask clear lands");
        tick(1);
        expect_irq(0, 1'b0, "irq after mask clear");
        bus_write(2'd2, 32'h01);
        tick(1);
        expect_irq(0, 1'b1, "irq after mask restore");

        // Async reset mid-debounce with irq high
        in_port = 8'h21;
        tick(3);
        expect_rd(0, 2'd0, 32'h0, "data cleared by async reset");
        expect_irq(0, 1'b0, "irq cleared by async reset");
        #2;
        reset_n = 1'b0;
        tick(1);
        expect_rd(0, 2'd2, 32'h0, "mask cleared by reset");
        tick(1);
        expect_rd(0, 2'd3, 32'h0, "capture cleared by reset");
        tick(1);
        expect_rd(0, 2'd1, 32'h0, "addr1 during reset");
        tick(1);
        reset_n = 1'b1;

        // Input held through release debounces from zero
        tick(5);
        expect_rd(0, 2'd0, 32'h0, "data at r+5 after release");
        tick(1);
        for (int d = 0; d < 3; d++) begin
            expect_rd(d, 2'd0, 32'h21, "held input after release");
        end
        tick(1);
        for (int d = 0; d < 3; d++) begin
            expect_rd(d, 2'd3, (d == 1) ? 32'h0 : 32'h21, "capture after release");
        end
        expect_irq(0, 1'b0, "irq after release mask 0");
        tick(1);
        for (int d = 0; d < 3; d++) begin
            expect_rd(d, 2'd1, 32'h0, "addr1 reads zero");
        end
        tick(2);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            tick(1);
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
